// File: rtl/flux_sched_pkg.sv
// Shared types and constants for the FLUX round-robin scheduler.
// Optional grant statistics are enabled by defining FLUX_SCHED_STATS_EN.
package flux_sched_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam int CNT_W  = 8;
  localparam int STAT_W = 16;

  function automatic int tag_width(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

endpackage

// File: rtl/flux_rr_scheduler_rr_pick.sv
// Circular first-one search over req, starting at index start.
// Combinational; hit is low when no request bit is set.
module rr_pick
  import flux_sched_pkg::*;
#(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = tag_width(FLUX)
) (
  input  logic [FLUX-1:0]      req,
  input  logic [TAG_WIDTH-1:0] start,
  output logic                 hit,
  output logic [TAG_WIDTH-1:0] idx
);

  int p;

  // Walk from farthest to nearest so the nearest hit is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    p   = 0;
    for (int k = FLUX - 1; k >= 0; k--) begin
      p = int'(start) + k;
      if (p >= FLUX) p = p - FLUX;
      if (req[p]) begin
        hit = 1'b1;
        idx = TAG_WIDTH'(p);
      end
    end
  end

endmodule

// File: rtl/flux_rr_scheduler.sv
// Round-robin, burst-bounded scheduler sharing one datapath among FLUX fluxes.
// Define FLUX_SCHED_STATS_EN to build the per-flux saturating grant counters.
module flux_rr_scheduler
  import flux_sched_pkg::*;
#(
  parameter int FLUX      = 2,
  parameter int BURST_LEN = 4,
  parameter int TAG_WIDTH = tag_width(FLUX)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [FLUX-1:0]        in_empty,
  input  logic [FLUX-1:0]        out_full,
  output logic [FLUX-1:0]        rd,
  output logic                   wr,
  output logic [TAG_WIDTH-1:0]   tag,
  output logic [FLUX*STAT_W-1:0] grant_count,
  input  logic                   stats_clr
);

  localparam logic [TAG_WIDTH-1:0] LAST = TAG_WIDTH'(FLUX - 1);
  localparam logic [CNT_W-1:0]     BMAX = CNT_W'(BURST_LEN);

  state_t               state, nstate;
  logic [TAG_WIDTH-1:0] ptr, nptr;
  logic [TAG_WIDTH-1:0] cur, ncur;
  logic [CNT_W-1:0]     cnt, ncnt;

  logic [FLUX-1:0]      elig;
  logic [TAG_WIDTH-1:0] ptr_eff;
  logic [TAG_WIDTH-1:0] pick_start;
  logic [TAG_WIDTH-1:0] pidx;
  logic [TAG_WIDTH-1:0] gidx;
  logic                 hit;
  logic                 grant;

  assign elig       = ~in_empty & ~out_full;
  assign ptr_eff    = (cur == LAST) ? '0 : cur + 1'b1;
  assign pick_start = (state == BURST) ? ptr_eff : ptr;

  rr_pick #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_pick (
    .req   (elig),
    .start (pick_start),
    .hit   (hit),
    .idx   (pidx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      cur   <= '0;
      cnt   <= '0;
    end else begin
      state <= nstate;
      ptr   <= nptr;
      cur   <= ncur;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    grant  = 1'b0;
    gidx   = '0;
    nstate = state;
    nptr   = ptr;
    ncur   = cur;
    ncnt   = cnt;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            grant = 1'b1;
            gidx  = pidx;
            ncur  = pidx;
            ncnt  = CNT_W'(1);
            if (BURST_LEN == 1) begin
              nptr = (pidx == LAST) ? '0 : pidx + 1'b1;
            end else begin
              nstate = BURST;
            end
          end
        end
        BURST: begin
          if (elig[cur] && cnt < BMAX) begin
            grant = 1'b1;
            gidx  = cur;
            ncnt  = cnt + 1'b1;
          end else begin
            // Release and re-arbitrate in the same cycle: no bubble.
            nptr = ptr_eff;
            if (hit) begin
              grant = 1'b1;
              gidx  = pidx;
              ncur  = pidx;
              ncnt  = CNT_W'(1);
            end else begin
              nstate = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd  = '0;
    tag = '0;
    if (grant && !reset) begin
      rd  = FLUX'(1) << gidx;
      tag = gidx;
    end
  end

  assign wr = |rd;

`ifdef FLUX_SCHED_STATS_EN
  for (genvar i = 0; i < FLUX; i++) begin : g_stat
    logic [STAT_W-1:0] c;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        c <= '0;
      end else if (stats_clr) begin
        c <= '0;
      end else if (rd[i] && c != '1) begin
        c <= c + 1'b1;
      end
    end
    assign grant_count[STAT_W*i +: STAT_W] = c;
  end
`else
  logic stats_unused;
  assign stats_unused = stats_clr;
  assign grant_count  = '0;
`endif

endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Self-checking bench for flux_rr_scheduler (FLUX=4, BURST_LEN=2).
// Directed table, hand sequences and randomized traffic against a model.
module tb_flux_rr_scheduler;

  localparam int F  = 4;
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          stats_clr;
  logic [F-1:0]  in_empty;
  logic [F-1:0]  out_full;
  logic [F-1:0]  rd;
  logic          wr;
  logic [1:0]    tag;
  logic [F*16-1:0] grant_count;

  int checks = 0;
  int errors = 0;

  // Model: owner of the current burst (-1 = none), its run length,
  // and where the next idle search starts.
  int m_owner;
  int m_run;
  int m_ptr;

  typedef struct {
    logic         en;
    logic [F-1:0] empty;
    logic [F-1:0] full;
    logic [F-1:0] exp_rd;
    logic [1:0]   exp_tag;
  } vec_t;

  vec_t tbl[18];

  flux_rr_scheduler #(
    .FLUX      (F),
    .BURST_LEN (BL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .in_empty    (in_empty),
    .out_full    (out_full),
    .rd          (rd),
    .wr          (wr),
    .tag         (tag),
    .grant_count (grant_count),
    .stats_clr   (stats_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int search(input int from, input logic [F-1:0] el);
    for (int k = 0; k < F; k++) begin
      if (el[(from + k) % F]) return (from + k) % F;
    end
    return -1;
  endfunction

  function automatic int predict();
    logic [F-1:0] el;
    el = ~in_empty & ~out_full;
    if (reset || !en) return -1;
    if (m_owner >= 0 && el[m_owner] && m_run < BL) return m_owner;
    if (m_owner >= 0) return search((m_owner + 1) % F, el);
    return search(m_ptr, el);
  endfunction

  task automatic commit(input int g);
    logic [F-1:0] el;
    el = ~in_empty & ~out_full;
    if (reset) begin
      m_owner = -1;
      m_run   = 0;
      m_ptr   = 0;
    end else if (!en) begin
      m_owner = m_owner;
    end else if (m_owner >= 0 && el[m_owner] && m_run < BL) begin
      m_run++;
    end else if (m_owner >= 0) begin
      m_ptr = (m_owner + 1) % F;
      if (g >= 0) begin
        m_owner = g;
        m_run   = 1;
      end else begin
        m_owner = -1;
      end
    end else if (g >= 0) begin
      if (BL == 1) m_ptr = (g + 1) % F;
      else begin
        m_owner = g;
        m_run   = 1;
      end
    end
  endtask

  task automatic step(input string name);
    int g;
    logic [F-1:0] er;
    #1;
    g  = predict();
    er = (g >= 0) ? (F'(1) << g) : '0;
    check({name, "_rd"}, 64'(rd), 64'(er));
    check({name, "_wr"}, 64'(wr), 64'(|er));
    check({name, "_tag"}, 64'(tag), 64'((g >= 0) ? g : 0));
    commit(g);
  endtask

  task automatic drive(input logic e, input logic [F-1:0] emp,
                       input logic [F-1:0] ful);
    en       = e;
    in_empty = emp;
    out_full = ful;
  endtask

  initial begin
    // Burst limit: all eligible, tags 0,0,1,1,2,2,3,3,0,0.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{1'b1, 4'b0000, 4'b0000,
                 4'(1 << ((i / 2) % 4)), 2'((i / 2) % 4)};
    tbl[10] = '{1'b1, 4'b1101, 4'b0000, 4'b0010, 2'd1};
    tbl[11] = '{1'b1, 4'b0110, 4'b0000, 4'b1000, 2'd3};
    tbl[12] = '{1'b1, 4'b1011, 4'b0100, 4'b0000, 2'd0};
    tbl[13] = '{1'b1, 4'b1011, 4'b0100, 4'b0000, 2'd0};
    tbl[14] = '{1'b1, 4'b1011, 4'b0000, 4'b0100, 2'd2};
    tbl[15] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0};
    tbl[16] = '{1'b1, 4'b0000, 4'b0000, 4'b0100, 2'd2};
    tbl[17] = '{1'b1, 4'b0000, 4'b0000, 4'b1000, 2'd3};

    reset     = 1'b1;
    stats_clr = 1'b0;
    drive(1'b1, '0, '0);
    commit(-1);
    @(negedge clk);
    #1;
    check("reset_rd", 64'(rd), 64'(0));
    check("reset_wr", 64'(wr), 64'(0));
    check("reset_tag", 64'(tag), 64'(0));
    check("reset_count", grant_count, 64'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].en, tbl[i].empty, tbl[i].full);
      #1;
      check($sformatf("tbl%0d_rd", i), 64'(rd), 64'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_wr", i), 64'(wr), 64'(|tbl[i].exp_rd));
      check($sformatf("tbl%0d_tag", i), 64'(tag), 64'(tbl[i].exp_tag));
      commit(predict());
      @(negedge clk);
    end

    // Asynchronous reset mid-burst, then restart from flux 0.
    drive(1'b1, '0, '0);
    step("preasync");
    #2;
    reset = 1'b1;
    #1;
    check("async_rd", 64'(rd), 64'(0));
    check("async_wr", 64'(wr), 64'(0));
    check("async_tag", 64'(tag), 64'(0));
    commit(-1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_tag", 64'(tag), 64'(0));
    check("post_reset_rd", 64'(rd), 64'(1));
    #0;
    commit(predict());
    @(negedge clk);

    // Sole eligible flux 0, freeze with en=0, then open flux 1 too.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1110, '0);
      step("sole");
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1110, '0);
      step("frozen");
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b1100, '0);
      step("resume");
      @(negedge clk);
    end

    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(63) == 0);
      drive($urandom_range(7) != 0,
            4'($urandom & $urandom), 4'($urandom & $urandom));
      step("rand");
      @(negedge clk);
    end
    reset = 1'b0;

`ifdef FLUX_SCHED_STATS_EN
    stats_clr = 1'b1;
    drive(1'b0, '0, '0);
    @(negedge clk);
    stats_clr = 1'b0;
    drive(1'b1, 4'b1101, '0);
    repeat (10) @(negedge clk);
    check("stat_ten", 64'(grant_count[31:16]), 64'(10));
    check("stat_other", 64'(grant_count[15:0]), 64'(0));
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    check("stat_clr_wins", 64'(grant_count[31:16]), 64'(0));
    @(negedge clk);
    repeat (65534) @(negedge clk);
    check("stat_ffff", 64'(grant_count[31:16]), 64'h0FFFF);
    @(negedge clk);
    check("stat_sat", 64'(grant_count[31:16]), 64'h0FFFF);
`else
    stats_clr = 1'b1;
    drive(1'b1, '0, '0);
    repeat (5) @(negedge clk);
    stats_clr = 1'b0;
    drive(1'b1, 4'b1101, '0);
    repeat (5) @(negedge clk);
    check("stat_tied", grant_count, 64'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
